instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of control_unit: holds the PC and issues reads to a
//  1-cycle-latency synchronous instruction memory. Responses are buffered in a small FIFO, and

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage feeding decode.
//   Holds the PC and issues reads to a 1-cycle-latency synchronous instruction memory.
//   Responses land in a small FIFO. The head entry is presented with pre-sliced
//   opcode/funct3/funct7 fields under a valid/ready handshake. A redirect flushes the
//   FIFO and kills any in-flight read.
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   imem_en/imem_addr          read strobe and word-aligned address; data returns next cycle
//   imem_rdata                 instruction word for the read issued last cycle
//   redirect_valid/_pc         taken branch / jump pulse and new fetch target
//   if_valid/if_ready          head-entry handshake with decode
//   if_instr/if_pc             head instruction and its PC (NOP / 0 when empty)
//   if_opcode/funct3/funct7    field slices of if_instr
//   misalign_err               only when IFETCH_MISALIGN_CHK_EN is defined: 1-cycle
//                              pulse after a redirect to a non-word-aligned target
// Build option: `define IFETCH_MISALIGN_CHK_EN adds the misalign_err port.
module instr_fetch_unit #(
    parameter int unsigned         XLEN       = 32,
    parameter logic [XLEN-1:0]     RESET_PC   = '0,
    parameter int unsigned         FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode,
    output logic [2:0]      if_funct3,
    output logic [6:0]      if_funct7
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_err
`endif
);

    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned SW  = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [SW-1:0]   credit_used;

    // Handshake and credit: an in-flight read always owns a FIFO slot
    always_comb begin
        pop         = if_valid & if_ready & ~redirect_valid;
        push        = inflight_q & ~redirect_valid;
        credit_used = SW'(count_q) + SW'(inflight_q) - SW'(pop);
        issue       = ~reset & ~redirect_valid & (credit_used < SW'(FIFO_DEPTH));
    end

    assign imem_en   = issue;
    assign imem_addr = pc_q;

    // Next-state for PC, in-flight tracking and FIFO pointers
    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc & ~XLEN'(3);
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) pc_d = XLEN'(pc_q + XLEN'(4));
            count_d = CW'(count_q + CW'(push) - CW'(pop));
            if (push) wr_ptr_d = AW'(wr_ptr_q + AW'(1));
            if (pop)  rd_ptr_d = AW'(rd_ptr_q + AW'(1));
        end
    end

    // Control state; reset dominates redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Datapath storage: PC of the outstanding read and the FIFO entries
    always_ff @(posedge clk) begin
        if (issue) inflight_pc_q <= pc_q;
        if (push && !reset) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    // Head presentation straight from FIFO registers
    always_comb begin
        if_valid  = (count_q != '0);
        if_instr  = if_valid ? instr_mem_q[rd_ptr_q] : NOP;
        if_pc     = if_valid ? pc_mem_q[rd_ptr_q]    : '0;
        if_opcode = if_instr[6:0];
        if_funct3 = if_instr[14:12];
        if_funct7 = if_instr[31:25];
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_q;

    // One-cycle flag for a redirect target with low address bits set
    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end

    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (XLEN=32, RESET_PC=0, FIFO_DEPTH=2).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic [2:0]  if_funct3;
    logic [6:0]  if_funct7;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode),
        .if_funct3      (if_funct3),
        .if_funct7      (if_funct7)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    // Address-derived instruction word: opcode 0x13, upper fields follow the address
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[23:0], 8'h93};
    endfunction

    // Synchronous 1-cycle memory
    always @(posedge clk) begin
        imem_rdata <= imem_en ? imem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc);
        logic [31:0] w;
        w = imem_word(exp_pc);
        check({tag, "_valid"}, 32'(if_valid), 32'd1);
        check({tag, "_pc"},    if_pc, exp_pc);
        check({tag, "_instr"}, if_instr, w);
        check({tag, "_opc"},   32'(if_opcode), 32'(w[6:0]));
        check({tag, "_f3"},    32'(if_funct3), 32'(w[14:12]));
        check({tag, "_f7"},    32'(if_funct7), 32'(w[31:25]));
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_pc;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        next_cycle(); next_cycle(); #1;
        check("rst_en",    32'(imem_en),  32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr,      32'h0000_0013);
        check("rst_pc",    if_pc,         32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("rst_mis",   32'(misalign_err), 32'd0);
`endif
        // Redirect during reset must be ignored
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        next_cycle();
        redirect_valid = 1'b0; reset = 1'b0; #1;
        check("start_en",   32'(imem_en), 32'd1);
        check("start_addr", imem_addr,    32'h0);
        next_cycle(); #1;
        check("c1_addr",  imem_addr,       32'h4);
        check("c1_valid", 32'(if_valid),   32'd0);

        // Streaming: one instruction per cycle, no gaps
        for (int k = 2; k < 8; k++) begin
            next_cycle(); #1;
            check_head("stream", 32'(4 * (k - 2)));
            check("stream_addr", imem_addr, 32'(4 * k));
        end

        // Stall: exactly two entries buffered, fetch stops
        if_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle(); #1;
            check("stall_en", 32'(imem_en), 32'd0);
            check_head("stall", 32'h14);
        end

        // Release: in-order contiguous drain with no bubbles
        if_ready = 1'b1;
        exp_pc = 32'h14;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_head("drain", exp_pc);
            exp_pc += 32'h4;
            next_cycle();
        end

        // Redirect with an entry buffered and a read in flight
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        check("rd1_en", 32'(imem_en), 32'd0);
        next_cycle();
        redirect_valid = 1'b0; if_ready = 1'b1; #1;
        check("rd1_addr",  imem_addr,      32'h100);
        check("rd1_valid", 32'(if_valid),  32'd0);
        next_cycle(); #1;
        check("rd1_valid2", 32'(if_valid), 32'd0);
        check("rd1_addr2",  imem_addr,     32'h104);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            check_head("rd1", 32'(32'h100 + 4 * k));
        end

        // Redirect coincident with pop, then a second redirect to 0x200
        #1;
        check("rd2_pre_valid", 32'(if_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
        check("rd2_en", 32'(imem_en), 32'd0);
        next_cycle();
        redirect_pc = 32'h200; #1;
        check("rd2_flushed", 32'(if_valid), 32'd0);
        check("rd2_en2",     32'(imem_en),  32'd0);
        next_cycle();
        redirect_valid = 1'b0; #1;
        check("rd2_addr",  imem_addr,     32'h200);
        check("rd2_valid", 32'(if_valid), 32'd0);
        next_cycle(); #1;
        check("rd2_valid2", 32'(if_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            check_head("rd2", 32'(32'h200 + 4 * k));
        end

        // Misaligned redirect target: aligned address used
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        next_cycle();
        redirect_valid = 1'b0; #1;
        check("mis_addr", imem_addr, 32'h100);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("mis_pulse", 32'(misalign_err), 32'd1);
`endif
        next_cycle(); #1;
        check("mis_addr2", imem_addr, 32'h104);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("mis_clear", 32'(misalign_err), 32'd0);
`endif
        next_cycle(); #1;
        check_head("mis", 32'h100);
        next_cycle(); #1;
        check_head("mis", 32'h104);

        // Reset mid-stream with FIFO non-empty
        reset = 1'b1;
        next_cycle(); #1;
        check("mrst_valid", 32'(if_valid), 32'd0);
        check("mrst_instr", if_instr,      32'h0000_0013);
        check("mrst_pc",    if_pc,         32'h0);
        check("mrst_en",    32'(imem_en),  32'd0);
        reset = 1'b0; #1;
        check("mrst_addr", imem_addr,     32'h0);
        check("mrst_en2",  32'(imem_en),  32'd1);
        next_cycle(); next_cycle(); #1;
        check_head("mrst", 32'h0);
        next_cycle(); #1;
        check_head("mrst", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
